// File: rtl/rmii_tx_frame_monitor.sv
// RMII (100 Mbit/s, dibit per REFCLK) transmit frame monitor: strips preamble/SFD,
// assembles bytes, checks FCS/length/alignment and keeps good/bad frame counters.
module rmii_tx_frame_monitor #(
  parameter int MIN_PRE = 15,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TXEN,
  input  logic [1:0]  TXD,
  output logic [7:0]  DOUT,
  output logic        DOUT_VLD,
  output logic        DOUT_SOP,
  output logic        FRM_DONE,
  output logic [10:0] FRM_LEN,
  output logic        FRM_CRC_OK,
  output logic        FRM_LEN_ERR,
  output logic        FRM_ALIGN_ERR,
  output logic        FRM_PRE_ERR,
  output logic [15:0] GOOD_CNT,
  output logic [15:0] BAD_CNT,
  output logic        BUSY
);

  localparam logic [5:0]  PRE_MIN  = 6'(MIN_PRE);
  localparam logic [10:0] LEN_MIN  = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);
  localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;

  typedef enum logic [2:0] {S_WAIT, S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t      state, state_nxt;
  logic        pre_start, pre_inc, data_start, data_shift, data_end, pre_end;
  logic [5:0]  pre_cnt;
  logic [1:0]  phase;
  logic [5:0]  shreg;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [7:0]  byte_q;
  logic        byte_vld_q, byte_sop_q;
  logic        done_pend, done_pre;
  logic [7:0]  byte_new;

  logic        st_crc_ok, st_len_err, st_align_err, st_good;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_new = {TXD, shreg};
  assign BUSY     = (state == S_PRE) || (state == S_DATA);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pre_start  = 1'b0;
    pre_inc    = 1'b0;
    data_start = 1'b0;
    data_shift = 1'b0;
    data_end   = 1'b0;
    pre_end    = 1'b0;
    case (state)
      S_WAIT: if (!TXEN) state_nxt = S_IDLE;
      S_IDLE: begin
        if (TXEN) begin
          if (TXD == 2'b01) begin
            pre_start = 1'b1;
            state_nxt = S_PRE;
          end else begin
            state_nxt = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!TXEN) begin
          pre_end   = 1'b1;
          state_nxt = S_IDLE;
        end else if (TXD == 2'b01) begin
          pre_inc = 1'b1;
        end else if (TXD == 2'b11 && pre_cnt >= PRE_MIN) begin
          data_start = 1'b1;
          state_nxt  = S_DATA;
        end else begin
          state_nxt = S_DROP;
        end
      end
      S_DATA: begin
        if (TXEN) begin
          data_shift = 1'b1;
        end else begin
          data_end  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!TXEN) begin
          pre_end   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Frame bookkeeping (byte_cnt, phase, crc) stays untouched between end of
  // frame and the next SFD, so the status stage reads it one cycle later.
  assign st_crc_ok    = !done_pre && (crc == CRC_RES);
  assign st_len_err   = !done_pre && ((byte_cnt < LEN_MIN) || (byte_cnt > LEN_MAX));
  assign st_align_err = !done_pre && (phase != 2'd0);
  assign st_good      = st_crc_ok && !st_len_err && !st_align_err && !done_pre;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt       <= '0;
      phase         <= '0;
      shreg         <= '0;
      byte_cnt      <= '0;
      crc           <= 32'hFFFFFFFF;
      byte_q        <= '0;
      byte_vld_q    <= 1'b0;
      byte_sop_q    <= 1'b0;
      done_pend     <= 1'b0;
      done_pre      <= 1'b0;
      DOUT          <= '0;
      DOUT_VLD      <= 1'b0;
      DOUT_SOP      <= 1'b0;
      FRM_DONE      <= 1'b0;
      FRM_LEN       <= '0;
      FRM_CRC_OK    <= 1'b0;
      FRM_LEN_ERR   <= 1'b0;
      FRM_ALIGN_ERR <= 1'b0;
      FRM_PRE_ERR   <= 1'b0;
      GOOD_CNT      <= '0;
      BAD_CNT       <= '0;
    end else begin
      byte_vld_q <= 1'b0;
      done_pend  <= 1'b0;

      if (pre_start) pre_cnt <= 6'd1;
      else if (pre_inc && pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;

      if (data_start) begin
        phase    <= '0;
        byte_cnt <= '0;
        crc      <= 32'hFFFFFFFF;
      end

      if (data_shift) begin
        phase <= phase + 2'd1;
        case (phase)
          2'd0: shreg[1:0] <= TXD;
          2'd1: shreg[3:2] <= TXD;
          2'd2: shreg[5:4] <= TXD;
          default: begin
            byte_q     <= byte_new;
            byte_vld_q <= 1'b1;
            byte_sop_q <= (byte_cnt == 11'd0);
            crc        <= crc32_byte(crc, byte_new);
            if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
          end
        endcase
      end

      if (data_end) begin
        done_pend <= 1'b1;
        done_pre  <= 1'b0;
      end else if (pre_end) begin
        done_pend <= 1'b1;
        done_pre  <= 1'b1;
      end

      DOUT_VLD <= byte_vld_q;
      DOUT_SOP <= byte_vld_q && byte_sop_q;
      if (byte_vld_q) DOUT <= byte_q;

      FRM_DONE <= done_pend;
      if (done_pend) begin
        FRM_LEN       <= done_pre ? 11'd0 : byte_cnt;
        FRM_CRC_OK    <= st_crc_ok;
        FRM_LEN_ERR   <= st_len_err;
        FRM_ALIGN_ERR <= st_align_err;
        FRM_PRE_ERR   <= done_pre;
        if (st_good) GOOD_CNT <= GOOD_CNT + 16'd1;
        else         BAD_CNT  <= BAD_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rmii_tx_frame_monitor.sv
// Scoreboard bench: stimulus pushes expected bytes/frame status, monitor pops on DOUT_VLD/FRM_DONE.
module tb_rmii_tx_frame_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        TXEN;
  logic [1:0]  TXD;
  logic [7:0]  DOUT;
  logic        DOUT_VLD, DOUT_SOP, FRM_DONE;
  logic [10:0] FRM_LEN;
  logic        FRM_CRC_OK, FRM_LEN_ERR, FRM_ALIGN_ERR, FRM_PRE_ERR;
  logic [15:0] GOOD_CNT, BAD_CNT;
  logic        BUSY;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int len;
    int crc_ok;
    int len_err;
    int align;
    int pre;
    int good;
    int bad;
  } frm_t;

  logic [8:0] exp_bytes[$];
  frm_t       exp_frames[$];
  int         exp_good = 0;
  int         exp_bad  = 0;

  rmii_tx_frame_monitor dut (
    .CLK(CLK), .RST(RST), .TXEN(TXEN), .TXD(TXD),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_SOP(DOUT_SOP),
    .FRM_DONE(FRM_DONE), .FRM_LEN(FRM_LEN), .FRM_CRC_OK(FRM_CRC_OK),
    .FRM_LEN_ERR(FRM_LEN_ERR), .FRM_ALIGN_ERR(FRM_ALIGN_ERR),
    .FRM_PRE_ERR(FRM_PRE_ERR), .GOOD_CNT(GOOD_CNT), .BAD_CNT(BAD_CNT),
    .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic r, input logic en, input logic [1:0] d);
    @(negedge CLK);
    RST  = r;
    TXEN = en;
    TXD  = d;
  endtask

  task automatic push_status(input int len, input int crc_ok, input int len_err,
                             input int align, input int pre);
    frm_t f;
    int good;
    good = (crc_ok == 1 && len_err == 0 && align == 0 && pre == 0) ? 1 : 0;
    if (good == 1) exp_good = (exp_good + 1) & 16'hFFFF;
    else           exp_bad  = (exp_bad + 1) & 16'hFFFF;
    f.len = len; f.crc_ok = crc_ok; f.len_err = len_err;
    f.align = align; f.pre = pre; f.good = exp_good; f.bad = exp_bad;
    exp_frames.push_back(f);
  endtask

  // npay payload bytes (i & 0xFF) plus FCS; rst_at >= 0 pulses RST on the first
  // dibit of that byte index, which also swallows the byte completed just before.
  task automatic send_frame(input int npre, input int npay, input bit flip,
                            input int extra, input int rst_at, input bit push_bytes,
                            input int gap);
    logic [7:0]  fr[$];
    logic [31:0] c;
    logic [7:0]  b;
    logic [1:0]  xd;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      b = 8'(i);
      fr.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) begin
      b = c[8*i +: 8];
      if (flip && i == 0) b[0] = ~b[0];
      fr.push_back(b);
    end
    if (push_bytes) begin
      for (int i = 0; i < fr.size(); i++) begin
        if (rst_at < 0 || i < rst_at - 1)
          exp_bytes.push_back({(i == 0) ? 1'b1 : 1'b0, fr[i]});
      end
    end
    for (int i = 0; i < npre; i++) drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b11);
    for (int i = 0; i < fr.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = fr[i];
        xd = b[2*k +: 2];
        if (i == rst_at && k == 0) begin
          drive(1'b1, 1'b1, xd);
          exp_good = 0;
          exp_bad  = 0;
        end else begin
          drive(1'b0, 1'b1, xd);
          if (i == rst_at && k == 1) begin
            chk("rst_good_cnt", GOOD_CNT, 0);
            chk("rst_bad_cnt", BAD_CNT, 0);
            chk("rst_frm_done", FRM_DONE, 0);
            chk("rst_dout_vld", DOUT_VLD, 0);
            chk("rst_busy", BUSY, 0);
          end
        end
      end
    end
    for (int i = 0; i < extra; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b01);
    for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 2'b00);
  endtask

  // Monitor: samples just after each active edge, independent of stimulus.
  initial begin
    logic [8:0] eb;
    frm_t f;
    forever begin
      @(posedge CLK);
      #1;
      if (DOUT_VLD) begin
        if (exp_bytes.size() == 0) begin
          chk("unexpected_dout_vld", 1, 0);
        end else begin
          eb = exp_bytes.pop_front();
          chk("dout", DOUT, eb[7:0]);
          chk("dout_sop", DOUT_SOP, eb[8]);
        end
      end else begin
        if (DOUT_SOP) chk("sop_without_vld", 1, 0);
      end
      if (FRM_DONE) begin
        if (exp_frames.size() == 0) begin
          chk("unexpected_frm_done", 1, 0);
        end else begin
          f = exp_frames.pop_front();
          chk("frm_len", FRM_LEN, f.len);
          chk("frm_crc_ok", FRM_CRC_OK, f.crc_ok);
          chk("frm_len_err", FRM_LEN_ERR, f.len_err);
          chk("frm_align_err", FRM_ALIGN_ERR, f.align);
          chk("frm_pre_err", FRM_PRE_ERR, f.pre);
          chk("good_cnt", GOOD_CNT, f.good);
          chk("bad_cnt", BAD_CNT, f.bad);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_frames.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_bytes_left"}, exp_bytes.size(), 0);
    chk({name, "_frames_left"}, exp_frames.size(), 0);
  endtask

  initial begin
    RST = 1'b1; TXEN = 1'b0; TXD = 2'b00;
    repeat (3) @(negedge CLK);
    chk("reset_dout", DOUT, 0);
    chk("reset_dout_vld", DOUT_VLD, 0);
    chk("reset_frm_done", FRM_DONE, 0);
    chk("reset_frm_len", FRM_LEN, 0);
    chk("reset_crc_ok", FRM_CRC_OK, 0);
    chk("reset_good_cnt", GOOD_CNT, 0);
    chk("reset_bad_cnt", BAD_CNT, 0);
    chk("reset_busy", BUSY, 0);
    drive(1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b0, 2'b00);

    // good 64-byte frame
    push_status(64, 1, 0, 0, 0);
    send_frame(31, 60, 1'b0, 0, -1, 1'b1, 4);
    // FCS bit 0 flipped
    push_status(64, 0, 0, 0, 0);
    send_frame(31, 60, 1'b1, 0, -1, 1'b1, 4);
    // two trailing dibits
    push_status(64, 1, 0, 1, 0);
    send_frame(31, 60, 1'b0, 2, -1, 1'b1, 4);
    // short preamble: 20 bytes dropped
    push_status(0, 0, 0, 0, 1);
    send_frame(10, 16, 1'b0, 0, -1, 1'b0, 4);
    // runt and oversize, both with valid FCS
    push_status(40, 1, 1, 0, 0);
    send_frame(31, 36, 1'b0, 0, -1, 1'b1, 4);
    push_status(1600, 1, 1, 0, 0);
    send_frame(31, 1596, 1'b0, 0, -1, 1'b1, 4);
    drain("pre_reset");

    // reset at byte 20, then a good frame after a 1-cycle gap
    send_frame(31, 60, 1'b0, 0, 20, 1'b1, 1);
    push_status(64, 1, 0, 0, 0);
    send_frame(31, 60, 1'b0, 0, -1, 1'b1, 4);
    drain("final");
    chk("final_good_cnt", GOOD_CNT, 1);
    chk("final_bad_cnt", BAD_CNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
